// File: rtl/pwm_version2.sv
// PWM generator: free-running counter, registered pwm and end-of-period flag.
// Optional PWM_SHADOW_DUTY_EN latches dato at each period wrap; otherwise dato is used directly.
// Latency: one clk from dato to pwm; no backpressure (free-running, no stall).
module pwm_version2 #(
    parameter int               WIDTH     = 22,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dato,
    output logic             pwm,
    output logic [WIDTH-1:0] counter,
    output logic             fin_periodo
);

    logic [WIDTH-1:0] counter_q, counter_d;
    logic             pwm_q, pwm_d;
    logic             fin_periodo_q, fin_periodo_d;
    logic [WIDTH-1:0] duty_active;
    logic             wrap;

`ifdef PWM_SHADOW_DUTY_EN
    logic [WIDTH-1:0] duty_q, duty_d;
`endif

    always_comb begin
        wrap      = (counter_q == MAX_COUNT);
        counter_d = wrap ? '0 : counter_q + WIDTH'(1);
`ifdef PWM_SHADOW_DUTY_EN
        // New duty is visible in the same cycle the counter returns to 0.
        duty_d      = wrap ? dato : duty_q;
        duty_active = duty_d;
`else
        duty_active = dato;
`endif
        // pwm is computed from the next counter value so it lines up with counter.
        pwm_d         = (counter_d < duty_active);
        fin_periodo_d = (counter_d == MAX_COUNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q     <= '0;
            pwm_q         <= 1'b0;
            fin_periodo_q <= 1'b0;
`ifdef PWM_SHADOW_DUTY_EN
            duty_q        <= '0;
`endif
        end else begin
            counter_q     <= counter_d;
            pwm_q         <= pwm_d;
            fin_periodo_q <= fin_periodo_d;
`ifdef PWM_SHADOW_DUTY_EN
            duty_q        <= duty_d;
`endif
        end
    end

    assign counter     = counter_q;
    assign pwm         = pwm_q;
    assign fin_periodo = fin_periodo_q;

endmodule

// File: tb/tb_pwm_version2.sv
// Directed bench for pwm_version2: MAX_COUNT=9 main instance plus a WIDTH=4 default-terminal instance.
module tb_pwm_version2;

    logic        clk;
    logic        rst_n;
    logic [21:0] dato;
    logic        pwm;
    logic [21:0] counter;
    logic        fin_periodo;
    logic [3:0]  dato4;
    logic        pwm4;
    logic [3:0]  counter4;
    logic        fin4;

    int tests;
    int fails;

    logic [31:0] exp_cnt, exp_duty, exp4, exp_duty4;

    pwm_version2 #(.WIDTH(22), .MAX_COUNT(22'd9)) dut (
        .clk(clk), .rst_n(rst_n), .dato(dato),
        .pwm(pwm), .counter(counter), .fin_periodo(fin_periodo)
    );

    pwm_version2 #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .dato(dato4),
        .pwm(pwm4), .counter(counter4), .fin_periodo(fin4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_cnt   = 0;
        exp_duty  = 0;
        exp4      = 0;
        exp_duty4 = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_counter"}, 32'(counter), 32'd0);
        chk({tag, "_pwm"}, 32'(pwm), 32'd0);
        chk({tag, "_fin"}, 32'(fin_periodo), 32'd0);
        chk({tag, "_counter4"}, 32'(counter4), 32'd0);
        chk({tag, "_pwm4"}, 32'(pwm4), 32'd0);
        chk({tag, "_fin4"}, 32'(fin4), 32'd0);
    endtask

    // Advance one clock and compare both instances against the reference period model.
    task automatic step();
        @(negedge clk);
        exp_cnt = (exp_cnt == 32'd9)  ? 32'd0 : exp_cnt + 32'd1;
        exp4    = (exp4    == 32'd15) ? 32'd0 : exp4 + 32'd1;
`ifdef PWM_SHADOW_DUTY_EN
        if (exp_cnt == 0) exp_duty = 32'(dato);
        if (exp4 == 0)    exp_duty4 = 32'(dato4);
`else
        exp_duty  = 32'(dato);
        exp_duty4 = 32'(dato4);
`endif
        chk("counter", 32'(counter), exp_cnt);
        chk("pwm", 32'(pwm), {31'd0, exp_cnt < exp_duty});
        chk("fin_periodo", 32'(fin_periodo), {31'd0, exp_cnt == 32'd9});
        chk("counter4", 32'(counter4), exp4);
        chk("pwm4", 32'(pwm4), {31'd0, exp4 < exp_duty4});
        chk("fin4", 32'(fin4), {31'd0, exp4 == 32'd15});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model counter reaches target; an expired bound is a failure.
    task automatic run_to(input logic [31:0] target);
        for (int i = 0; i < 12 && exp_cnt != target; i++) step();
        chk("run_to_bound", exp_cnt, target);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        dato  = 22'd5;
        dato4 = 4'd8;
        model_reset();
        #2;
        chk_reset("por");

        @(negedge clk);
        rst_n = 1'b1;
        step();
`ifdef PWM_SHADOW_DUTY_EN
        chk("first_edge_pwm", 32'(pwm), 32'd0);
`else
        chk("first_edge_pwm", 32'(pwm), 32'd1);
`endif
        chk("first_edge_counter", 32'(counter), 32'd1);
        run(2);

        // Asynchronous reset between edges, dato=5.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("async_rst");
        @(negedge clk);
        chk_reset("async_rst_hold");
        model_reset();
        rst_n = 1'b1;
        dato  = 22'd4;
        run(25);

        dato = 22'd0;
        run(12);
        dato = 22'd10;
        run(12);
        dato = 22'h3FFFFF;
        run(12);
        dato = 22'd9;
        run(12);

        // Mid-period duty change from 2 to 7.
        dato = 22'd2;
        run(10);
        run_to(32'd4);
        dato = 22'd7;
        step();
`ifdef PWM_SHADOW_DUTY_EN
        chk("dato_change_c5", 32'(pwm), 32'd0);
`else
        chk("dato_change_c5", 32'(pwm), 32'd1);
`endif
        step();
`ifdef PWM_SHADOW_DUTY_EN
        chk("dato_change_c6", 32'(pwm), 32'd0);
`else
        chk("dato_change_c6", 32'(pwm), 32'd1);
`endif
        run(14);

        // Reset at counter 6 held for two cycles.
        run_to(32'd6);
        rst_n = 1'b0;
        #1 chk_reset("rst_c6");
        @(negedge clk);
        chk_reset("rst_c6_hold1");
        @(negedge clk);
        chk_reset("rst_c6_hold2");
        model_reset();
        rst_n = 1'b1;
        step();
        chk("resume_1", 32'(counter), 32'd1);
        step();
        chk("resume_2", 32'(counter), 32'd2);
        step();
        chk("resume_3", 32'(counter), 32'd3);
        run(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
